// File: rtl/operand_sequencer.sv
// Operand sequencer for the 3-bit ripple adder: debounced load button steps A -> B/cin -> sample sum.
// Operands are driven straight to the adder; its sum is latched after a settle delay.
module operand_sequencer #(
  parameter int DB_CYCLES     = 500000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_load,
  input  logic [2:0] sw,
  input  logic       cin_sw,
  input  logic [2:0] sum_in,
  output logic [2:0] first_bin,
  output logic [2:0] second_bin,
  output logic       cin,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [1:0] state_led
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  logic           r_sync1, r_sync2, r_db, r_press;
  logic [DBW-1:0] r_db_cnt;
  state_t         r_state;
  logic [STW-1:0] r_settle;
  logic [2:0]     r_first, r_second, r_result;
  logic           r_cin, r_valid;

  // Press is raised on the same edge the debounced level rises, so the FSM
  // reacts one edge later instead of waiting for a separate edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= btn_load;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
          r_db     <= ~r_db;
          r_db_cnt <= '0;
          r_press  <= ~r_db;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_A;
      r_settle <= '0;
      r_first  <= '0;
      r_second <= '0;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_A: if (r_press) begin
          r_first <= sw;
          r_state <= S_B;
        end
        S_B: if (r_press) begin
          r_second <= sw;
          r_cin    <= cin_sw;
          r_settle <= '0;
          r_state  <= S_WAIT;
        end
        // Presses arriving here are dropped on purpose.
        S_WAIT: if (r_settle == STW'(SETTLE_CYCLES)) begin
          r_result <= sum_in;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end else begin
          r_settle <= r_settle + 1'b1;
        end
        S_DONE: if (r_press) begin
          r_first  <= sw;
          r_second <= '0;
          r_cin    <= 1'b0;
          r_valid  <= 1'b0;
          r_state  <= S_B;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign first_bin    = r_first;
  assign second_bin   = r_second;
  assign cin          = r_cin;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign state_led    = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: a fast-settle and a slow-settle instance share stimulus and are
// checked every cycle against a timeline-based model, plus literal spot checks.
module tb_operand_sequencer;
  localparam int DB   = 4;
  localparam int ST_F = 2;
  localparam int ST_S = 16;

  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, cin_sw = 1'b0;
  logic [2:0] sw = 3'd0;
  logic [2:0] fb0, sb0, res0, sum0, fb1, sb1, res1, sum1;
  logic       c0, rv0, c1, rv1;
  logic [1:0] sl0, sl1;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int settle [2] = '{ST_F, ST_S};
  int m_s1[2], m_s2[2], m_db[2], m_run[2], m_press[2];
  int m_st[2], m_a[2], m_b[2], m_c[2], m_res[2], m_vld[2], m_cap[2];

  always #5 clk = ~clk;

  // Combinational 3-bit adders feeding sum_in; carry-out is dropped.
  assign sum0 = fb0 + sb0 + {2'b00, c0};
  assign sum1 = fb1 + sb1 + {2'b00, c1};

  operand_sequencer #(.DB_CYCLES(DB), .SETTLE_CYCLES(ST_F)) u_fast (
    .clk(clk), .rst_n(rst_n), .btn_load(btn), .sw(sw), .cin_sw(cin_sw), .sum_in(sum0),
    .first_bin(fb0), .second_bin(sb0), .cin(c0), .result(res0), .result_valid(rv0),
    .state_led(sl0));

  operand_sequencer #(.DB_CYCLES(DB), .SETTLE_CYCLES(ST_S)) u_slow (
    .clk(clk), .rst_n(rst_n), .btn_load(btn), .sw(sw), .cin_sw(cin_sw), .sum_in(sum1),
    .first_bin(fb1), .second_bin(sb1), .cin(c1), .result(res1), .result_valid(rv1),
    .state_led(sl1));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0; m_press[i] = 0;
      m_st[i] = 0; m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; m_res[i] = 0; m_vld[i] = 0;
      m_cap[i] = 0;
    end
  endtask

  // One rising edge: the FSM sees the press accepted on the previous edge; a press is
  // accepted once the synchronised button has disagreed with the accepted level DB times in a row.
  task automatic model_edge(input int b, input int s, input int ci);
    int np;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 0 && m_press[i] == 1) begin
        m_a[i] = s; m_st[i] = 1;
      end else if (m_st[i] == 1 && m_press[i] == 1) begin
        m_b[i] = s; m_c[i] = ci; m_st[i] = 2; m_cap[i] = cyc;
      end else if (m_st[i] == 2) begin
        if (cyc - m_cap[i] == settle[i] + 1) begin
          m_res[i] = (m_a[i] + m_b[i] + m_c[i]) % 8; m_vld[i] = 1; m_st[i] = 3;
        end
      end else if (m_st[i] == 3 && m_press[i] == 1) begin
        m_a[i] = s; m_b[i] = 0; m_c[i] = 0; m_vld[i] = 0; m_st[i] = 1;
      end
      np = 0;
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i] = 1 - m_db[i]; m_run[i] = 0; np = m_db[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_press[i] = np;
      m_s2[i] = m_s1[i];
      m_s1[i] = b;
    end
  endtask

  task automatic check_all();
    chk("first_bin0", int'(fb0), m_a[0]);   chk("first_bin1", int'(fb1), m_a[1]);
    chk("second_bin0", int'(sb0), m_b[0]);  chk("second_bin1", int'(sb1), m_b[1]);
    chk("cin0", int'(c0), m_c[0]);          chk("cin1", int'(c1), m_c[1]);
    chk("result0", int'(res0), m_res[0]);   chk("result1", int'(res1), m_res[1]);
    chk("valid0", int'(rv0), m_vld[0]);     chk("valid1", int'(rv1), m_vld[1]);
    chk("state0", int'(sl0), m_st[0]);      chk("state1", int'(sl1), m_st[1]);
  endtask

  // Called at a negedge; returns at the next negedge with the model advanced and compared.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(int'(btn), int'(sw), int'(cin_sw));
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic press(input logic [2:0] s, input logic ci, input int hold);
    sw = s; cin_sw = ci; btn = 1'b1;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (DB + 6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_reset();
    @(negedge clk);
    repeat (3) tick();
    chk("reset_state", int'(sl0), 0);
    chk("reset_first", int'(fb0), 0);
    rst_n = 1'b1;

    // Latency: raw rise just after a negedge, capture expected on edge DB+3.
    sw = 3'd3; btn = 1'b1; n = 0;
    while (fb0 != 3'd3 && n < 30) begin tick(); n++; end
    chk("press_latency", n, DB + 3);
    repeat (3) tick();
    btn = 1'b0;
    repeat (DB + 6) tick();

    press(3'd2, 1'b0, DB + 6);
    chk("s1_first", int'(fb0), 3); chk("s1_second", int'(sb0), 2);
    chk("s1_result", int'(res0), 5); chk("s1_valid", int'(rv0), 1);
    chk("s1_state", int'(sl0), 3);

    press(3'd7, 1'b0, DB + 6);
    press(3'd1, 1'b1, DB + 6);
    chk("s2_wrap", int'(res0), 1); chk("s2_valid", int'(rv0), 1);
    press(3'd4, 1'b0, DB + 6);
    chk("s2_first", int'(fb0), 4); chk("s2_second", int'(sb0), 0);
    chk("s2_valid_clr", int'(rv0), 0); chk("s2_state", int'(sl0), 1);
    chk("s2_result_kept", int'(res0), 1);

    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1; repeat (w) tick();
      btn = 1'b0; repeat (8) tick();
    end
    chk("s3_glitch_state", int'(sl0), 1);
    press(3'd5, 1'b1, 50);
    chk("s3_held_second", int'(sb0), 5); chk("s3_held_state", int'(sl0), 3);

    for (int k = 0; k < 30; k++)
      press(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));

    // Press landing in the slow instance's settle window must be dropped.
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
    press(3'd1, 1'b0, DB + 6);
    sw = 3'd6; btn = 1'b1; repeat (5) tick();
    btn = 1'b0; repeat (5) tick();
    sw = 3'd2; btn = 1'b1; repeat (10) tick();
    btn = 1'b0; repeat (10) tick();
    chk("s4_first", int'(fb1), 1); chk("s4_second", int'(sb1), 6);
    chk("s4_state", int'(sl1), 3);

    // Asynchronous reset between edges while the slow instance is settling.
    press(3'd3, 1'b0, DB + 6);
    sw = 3'd4; cin_sw = 1'b1; btn = 1'b1; repeat (10) tick();
    chk("s5_in_wait", int'(sl1), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_first", int'(fb1), 0); chk("s5_rst_second", int'(sb1), 0);
    chk("s5_rst_cin", int'(c1), 0); chk("s5_rst_state", int'(sl1), 0);
    chk("s5_rst_result", int'(res0), 0); chk("s5_rst_valid", int'(rv0), 0);
    model_reset();
    btn = 1'b0;
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    press(3'd2, 1'b0, DB + 6);
    press(3'd3, 1'b1, DB + 6);
    chk("s5_result_fast", int'(res0), 6);
    n = 0;
    while (!rv1 && n < 40) begin tick(); n++; end
    chk("s5_result_slow", int'(res1), 6); chk("s5_valid_slow", int'(rv1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
